// File: rtl/alu_seq.sv
// Sequential ALU: handshaked WIDTH-bit ops, registered result/flags, 1-bit-per-cycle shifter.
// Optional shift-add multiplier on op 12 is enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD      = 4'd0;
  localparam logic [3:0] OP_SUB      = 4'd1;
  localparam logic [3:0] OP_AND      = 4'd2;
  localparam logic [3:0] OP_OR       = 4'd3;
  localparam logic [3:0] OP_XOR      = 4'd4;
  localparam logic [3:0] OP_NOT      = 4'd5;
  localparam logic [3:0] OP_SHL      = 4'd6;
  localparam logic [3:0] OP_SHR      = 4'd7;
  localparam logic [3:0] OP_SAR      = 4'd8;
  localparam logic [3:0] OP_BOOL_AND = 4'd9;
  localparam logic [3:0] OP_BOOL_OR  = 4'd10;
  localparam logic [3:0] OP_BOOL_NOT = 4'd11;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL      = 4'd12;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
`ifdef ALU_SEQ_MUL_EN
    S_MUL,
`endif
    S_DONE
  } state_t;

  state_t             state, next_state;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               load;
  logic [WIDTH:0]     sum, diff;
  logic               big_shift;
  logic [WIDTH-1:0]   step_res;
  logic               step_bit;
`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif

  assign sum       = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff      = {1'b0, operand_a} - {1'b0, operand_b};
  assign big_shift = {1'b0, operand_b} >= (WIDTH+1)'(WIDTH);

  // One-bit step of the iterative shifter, driven by the latched opcode.
  always_comb begin
    step_res = {1'b0, work_q[WIDTH-1:1]};
    step_bit = work_q[0];
    case (op_q)
      OP_SHL:  begin
        step_res = {work_q[WIDTH-2:0], 1'b0};
        step_bit = work_q[WIDTH-1];
      end
      OP_SAR:  step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  // Next-state and datapath; the zero flag is refreshed only when a final result is written.
  always_comb begin
    next_state = state;
    op_d       = op_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    load       = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          op_d       = op;
          load       = 1'b1;
          next_state = S_DONE;
          result_d   = '0;
          carry_d    = 1'b0;
          case (op)
            OP_ADD:      {carry_d, result_d} = sum;
            OP_SUB:      {carry_d, result_d} = diff;
            OP_AND:      result_d = operand_a & operand_b;
            OP_OR:       result_d = operand_a | operand_b;
            OP_XOR:      result_d = operand_a ^ operand_b;
            OP_NOT:      result_d = ~operand_a;
            OP_BOOL_AND: result_d = {{(WIDTH-1){1'b0}}, (|operand_a) & (|operand_b)};
            OP_BOOL_OR:  result_d = {{(WIDTH-1){1'b0}}, (|operand_a) | (|operand_b)};
            OP_BOOL_NOT: result_d = {{(WIDTH-1){1'b0}}, ~(|operand_a)};
            OP_SHL, OP_SHR, OP_SAR: begin
              if (operand_b == '0) begin
                result_d = operand_a;
              end else if (big_shift) begin
                result_d = (op == OP_SAR) ? {WIDTH{operand_a[WIDTH-1]}} : '0;
              end else begin
                load       = 1'b0;
                work_d     = operand_a;
                cnt_d      = operand_b[SHAMT_W-1:0];
                next_state = S_SHIFT;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              load       = 1'b0;
              acc_d      = '0;
              mcand_d    = {{WIDTH{1'b0}}, operand_a};
              mplier_d   = operand_b;
              cnt_d      = SHAMT_W'(WIDTH);
              next_state = S_MUL;
            end
`endif
            default: ;
          endcase
        end
      end
      S_SHIFT: begin
        work_d  = step_res;
        carry_d = step_bit;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          result_d   = step_res;
          load       = 1'b1;
          next_state = S_DONE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          result_d   = acc_step[WIDTH-1:0];
          carry_d    = |acc_step[2*WIDTH-1:WIDTH];
          load       = 1'b1;
          next_state = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (load) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // A reset in mid-operation simply discards all working state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign in_ready   = (state == S_IDLE) && !rst;
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the 1-bit combinational ALU ops (add/sub, shifts, bitwise and boolean logic).
- Operates on WIDTH-bit operands with an opcode select and a valid/ready handshake on input and output.
- Has a registered result with carry/zero flags and an iterative 1-bit-per-cycle shifter.
- Sits between button/switch input logic and LED/display output in iCEBreaker designs.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2). The shift-count width is the localparam SHAMT_W = $clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- op  input  4  opcode
- operand_a  input  WIDTH  first operand
- operand_b  input  WIDTH  second operand / shift amount
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  registered result
- out_carry  output  1  carry/borrow/shifted-out/overflow flag
- out_zero  output  1  out_result == 0
- busy  output  1  state != IDLE

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 SHL, 7 SHR, 8 SAR.
  - 9 BOOL_AND, 10 BOOL_OR, 11 BOOL_NOT(a): these produce 0 or 1 zero-extended.
  - 12 MUL (optional feature).
  - 13-15 reserved: result 0, carry 0.
- Reset: state IDLE, out_valid 0, out_result 0, out_carry 0, out_zero 0, busy 0. in_ready reads 1 once rst deasserts.
- Reset mid-operation: operation abandoned, no output produced, all registers return to reset values.
- States:
  - IDLE: in_ready=1. Acceptance = in_valid & in_ready at edge T; operands and op are latched.
  - Non-shift, non-MUL ops: result and flags computed and registered at T, move to DONE. out_valid=1 from T+1.
  - Shifts: n = operand_b, treated as unsigned.
    - n=0: result = a, carry 0, DONE at T+1.
    - n>=WIDTH: SHL/SHR result 0; SAR result = all copies of a[WIDTH-1]; carry 0; DONE at T+1.
    - 1<=n<=WIDTH-1: enter SHIFT. Shift one bit per cycle, a down-counter loaded with n. out_valid at T+1+n.
  - SHIFT: each cycle shifts the working register by 1 and captures the bit shifted out into carry. On the last shift, move to DONE.
  - MUL: see optional feature.
  - DONE: out_valid=1, in_ready=0. out_result/out_carry/out_zero are held stable until out_ready=1 at an edge, then IDLE. in_valid is ignored while not in IDLE.
- Throughput: at most one op per 2 cycles. No input/output overlap.
- Arithmetic flags:
  - ADD carry = bit WIDTH of a+b.
  - SUB carry = borrow (a<b unsigned), result = a-b mod 2^WIDTH.
  - Shift carry = last bit shifted out.
  - Logic and bool carry = 0.
  - out_zero is computed from the final result, for all ops.
- Operands are sampled only at acceptance. Changes on operand_a, operand_b or op during SHIFT/MUL/DONE have no effect.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - op 12 = unsigned MUL, shift-add, one multiplier bit per cycle, WIDTH cycles in a MUL state. out_valid at T+1+WIDTH.
  - out_result = low WIDTH bits of the product; out_carry = 1 if the high WIDTH bits are nonzero.
- Not defined: no multiplier logic or MUL state. op 12 behaves as reserved (result 0, carry 0, out_valid at T+1).

Test Plan (WIDTH=8):
- ADD a=0xFF b=0x01 accepted at T -> out_valid at T+1, result 0x00, carry 1, zero 1. SUB a=0x03 b=0x05 -> 0xFE, carry 1, zero 0.
- SAR a=0x80 b=3 -> out_valid exactly at T+4, result 0xF0, carry 0, busy high T+1..T+4. SHR a=0x81 b=1 -> 0x40, carry 1, at T+2.
- SHL a=0x5A b=9 -> result 0x00, carry 0, out_valid at T+1. SAR a=0x80 b=200 -> 0xFF. SHL b=0 -> 0x5A.
- Backpressure: XOR a=0xF0 b=0x3C with out_ready low 5 cycles -> 0xCC held stable, in_ready 0, and a concurrent in_valid is not accepted. out_ready high -> IDLE next cycle, in_ready 1.
- rst pulsed at cycle 2 of SHL a=0x01 b=7 -> all outputs 0 immediately, no out_valid. Next BOOL_NOT a=0x00 -> result 0x01 at T+1.
- MUL, with ALU_SEQ_MUL_EN: a=0x10 b=0x11 -> result 0x10, carry 1, out_valid at T+9. Without the macro: result 0x00, carry 0, zero 1 at T+1.
